eep_access_arb: RTL and testbench
=================================

# eep_access_arb

Shared-access sequencer for the single serial-coefficient EEPROM used by the PID datapath. It arbitrates between two requesters: the control-loop sequencer, which reads Xset/P/I/D coefficients, and the command interpreter, which reads or writes coefficients. It drives the EEPROM chip-select, read/write, and address lines, and times the charge-pump window for writes. It returns captured read data and a one-cycle done pulse to whichever requester was granted.

## Interface
- WR_CYCLES, 1400000: charge-pump/write window length in clk cycles (3 ms at the system clock); legal range 1..2^CNT_W-1.
- CNT_W, 21: write-timer width.
- DATA_W, 14: EEPROM word width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ctl_req  in  1  control-loop read request, level, held until ctl_done.
- ctl_addr  in  2  control-loop coefficient address (00 Xset, 01 P, 10 I, 11 D).
- ctl_done  out  1  one-cycle pulse; rd_data is valid for the control loop.
- cmd_req  in  1  command-path request, level, held until cmd_done.
- cmd_wr  in  1  1 = write, 0 = read; sampled at grant.
- cmd_addr  in  2  command-path address; sampled at grant.
- cmd_wdata  in  DATA_W  write data; sampled at grant.
- cmd_done  out  1  one-cycle pulse; the command read or write is complete.
- rd_data  out  DATA_W  last captured EEPROM read word; held until the next read.
- busy  out  1  high in any state other than IDLE.
- eep_cs_n  out  1  EEPROM chip select, active low.
- eep_r_w_n  out  1  1 = read, 0 = write.
- eep_addr  out  2  EEPROM address.
- eep_wdata  out  DATA_W  EEPROM write data.
- eep_rdata  in  DATA_W  EEPROM read data; valid in the same cycle as cs_n=0 with r_w_n=1.
- chrg_pmp_en  out  1  charge-pump enable; high for the whole write window.

## Operation
- States: IDLE, RD, WR, DONE. At reset the state is IDLE, the owner is ctl, and last_gnt is cmd.
- IDLE, grant selection:
  - If only ctl_req is high, grant ctl.
  - If only cmd_req is high, grant cmd.
  - If both are high, grant the requester that was not granted last (round-robin on last_gnt).
  - On grant: latch the owner, the address, and (for cmd) cmd_wr and cmd_wdata.
  - Go to WR if the owner is cmd and cmd_wr=1; otherwise go to RD.
- RD (1 cycle): eep_cs_n=0, eep_r_w_n=1, eep_addr=latched address. At the clock edge, rd_data<=eep_rdata. Go to DONE.
- WR (WR_CYCLES cycles):
  - eep_cs_n=0, eep_r_w_n=0, chrg_pmp_en=1, eep_addr and eep_wdata held from the latched values.
  - The timer starts at 0 on entry and increments each cycle.
  - When the timer equals WR_CYCLES-1, clear the timer and go to DONE.
- DONE (1 cycle): pulse ctl_done or cmd_done according to the owner, update last_gnt to the owner, go to IDLE.
- Outside RD and WR: eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=0. eep_addr and eep_wdata hold their last values.
- A write is never preempted. A ctl_req that arrives during WR waits and is granted from the next IDLE.
- A requester that drops req after grant does not abort the transaction; its done still pulses.
- A req still high in the cycle after done is treated as a new request.
- rd_data is not modified by writes.

## Timing
- Reset values: eep_cs_n=1, eep_r_w_n=1, eep_addr=0, eep_wdata=0, chrg_pmp_en=0, ctl_done=0, cmd_done=0, rd_data=0, busy=0. The timer is 0.
- Read, with req sampled high in IDLE at edge N: RD during cycle N+1, done and valid rd_data during cycle N+2. Turnaround is 3 cycles per read.
- Write: WR spans cycles N+1..N+WR_CYCLES, cmd_done is high in cycle N+WR_CYCLES+1, and chrg_pmp_en is high for exactly WR_CYCLES cycles.
- All outputs are registered or decoded from state only; there is no combinational path from req to the eep_* outputs.
- Reset asserted mid-RD or mid-WR immediately forces eep_cs_n=1 and chrg_pmp_en=0 with no done pulse. After reset, the block is in IDLE.

## Test plan
- Control read alone (WR_CYCLES=8): ctl_req=1, ctl_addr=01, eep_rdata=0x1A5.
  - Expect eep_cs_n=0 / r_w_n=1 / addr=01 for 1 cycle.
  - Expect ctl_done 2 cycles after the request is sampled, rd_data=0x1A5.
  - Expect cmd_done to stay 0.
- Command write: cmd_req=1, cmd_wr=1, cmd_addr=10, cmd_wdata=0x2C3.
  - Expect chrg_pmp_en and eep_cs_n low with r_w_n=0 for exactly 8 cycles, with addr=10 and wdata=0x2C3 held.
  - Expect cmd_done in cycle 9. rd_data is unchanged.
- Simultaneous requests, both held across two transactions: expect grant order ctl then cmd.
  - Repeat after a fresh cmd-only transaction; expect ctl first again.
- ctl_req raised in the 3rd cycle of an 8-cycle write: write completes unshortened, cmd_done fires, then the ctl read completes 3 cycles later.
- rst_n pulsed low in WR cycle 4: eep_cs_n=1 and chrg_pmp_en=0 immediately, no done pulse, busy=0. A new read after release completes normally.
- Command read with cmd_wr=0, addr=11, eep_rdata=0x3FFF: cmd_done with rd_data=0x3FFF, and chrg_pmp_en never asserts.

Source files
------------

// File: rtl/eep_access_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : eep_access_arb                                               |
// | Description : Shared-access sequencer for the PID coefficient EEPROM.      |
// |               Round-robin arbitration between the control-loop reader and  |
// |               the command interpreter, EEPROM strobes, write-window timer. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module eep_access_arb #(
    parameter int WR_CYCLES = 1400000,
    parameter int CNT_W     = 21,
    parameter int DATA_W    = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctl_req,
    input  logic [1:0]        ctl_addr,
    output logic              ctl_done,
    input  logic              cmd_req,
    input  logic              cmd_wr,
    input  logic [1:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              eep_cs_n,
    output logic              eep_r_w_n,
    output logic [1:0]        eep_addr,
    output logic [DATA_W-1:0] eep_wdata,
    input  logic [DATA_W-1:0] eep_rdata,
    output logic              chrg_pmp_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic             c_own_ctl  = 1'b0;
    localparam logic             c_own_cmd  = 1'b1;
    localparam logic [CNT_W-1:0] c_wr_last  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_last_gnt;
    logic                r_wr;
    logic [1:0]          r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rd_data;
    logic [CNT_W-1:0]    r_timer;
    logic                w_grant;
    logic                w_gnt_owner;
    logic                w_timer_end;

    // Grant selection: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        w_grant     = ctl_req | cmd_req;
        w_gnt_owner = cmd_req ? c_own_cmd : c_own_ctl;
        if (ctl_req && cmd_req) begin
            w_gnt_owner = ~r_last_gnt;
        end
    end

    assign w_timer_end = (r_timer == c_wr_last);

    // Next-state and state-decoded outputs; nothing here looks at req, so eep_* stay glitch-free
    always_comb begin
        w_state_nxt = r_state;
        eep_cs_n    = 1'b1;
        eep_r_w_n   = 1'b1;
        chrg_pmp_en = 1'b0;
        busy        = 1'b1;
        ctl_done    = 1'b0;
        cmd_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_grant) begin
                    w_state_nxt = (w_gnt_owner == c_own_cmd && cmd_wr) ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                eep_cs_n    = 1'b0;
                w_state_nxt = ST_DONE;
            end
            ST_WR: begin
                eep_cs_n    = 1'b0;
                eep_r_w_n   = 1'b0;
                chrg_pmp_en = 1'b1;
                if (w_timer_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ctl_done    = (r_owner == c_own_ctl);
                cmd_done    = (r_owner == c_own_cmd);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction context latched at grant; last_gnt moves only when a transaction finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= c_own_ctl;
            r_last_gnt <= c_own_cmd;
            r_wr       <= 1'b0;
            r_addr     <= 2'b00;
            r_wdata    <= '0;
        end else begin
            if (r_state == ST_IDLE && w_grant) begin
                r_owner <= w_gnt_owner;
                if (w_gnt_owner == c_own_cmd) begin
                    r_addr  <= cmd_addr;
                    r_wr    <= cmd_wr;
                    r_wdata <= cmd_wdata;
                end else begin
                    r_addr  <= ctl_addr;
                    r_wr    <= 1'b0;
                end
            end
            if (r_state == ST_DONE) begin
                r_last_gnt <= r_owner;
            end
        end
    end

    // Write-window timer: counts from 0 on entry to WR and is cleared on the last window cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state == ST_WR && !w_timer_end) begin
            r_timer <= r_timer + c_cnt_one;
        end else begin
            r_timer <= '0;
        end
    end

    // Read-data capture during the single RD cycle; writes never touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (r_state == ST_RD) begin
            r_rd_data <= eep_rdata;
        end
    end

    assign rd_data   = r_rd_data;
    assign eep_addr  = r_addr;
    assign eep_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_eep_access_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_eep_access_arb                                            |
// | Description : Self-checking bench: directed vector table, corner-case      |
// |               sequences and a randomized run against a transaction model.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_eep_access_arb;

    localparam int W  = 8;
    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctl_req, cmd_req, cmd_wr;
    logic [1:0]    ctl_addr, cmd_addr;
    logic [DW-1:0] cmd_wdata, eep_rdata;
    logic          ctl_done, cmd_done, busy, eep_cs_n, eep_r_w_n, chrg_pmp_en;
    logic [DW-1:0] rd_data, eep_wdata;
    logic [1:0]    eep_addr;

    eep_access_arb #(.WR_CYCLES(W), .CNT_W(21), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctl_req(ctl_req), .ctl_addr(ctl_addr), .ctl_done(ctl_done),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_done(cmd_done), .rd_data(rd_data),
        .busy(busy), .eep_cs_n(eep_cs_n), .eep_r_w_n(eep_r_w_n),
        .eep_addr(eep_addr), .eep_wdata(eep_wdata), .eep_rdata(eep_rdata),
        .chrg_pmp_en(chrg_pmp_en)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic          ctl_req;
        logic [1:0]    ctl_addr;
        logic          cmd_req;
        logic          cmd_wr;
        logic [1:0]    cmd_addr;
        logic [DW-1:0] cmd_wdata;
        logic [DW-1:0] rdata;
        logic          exp_cmd;
        int            exp_lat;
        int            exp_cs;
        int            exp_pmp;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctl_req = 0; ctl_addr = 0; cmd_req = 0; cmd_wr = 0;
        cmd_addr = 0; cmd_wdata = 0; eep_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    // Run until a done pulse (bounded), checking strobes while the EEPROM is selected
    task automatic wait_done(input int max, input logic [1:0] exp_addr, input logic exp_wr,
                             input logic [DW-1:0] exp_wdata, output int lat,
                             output logic saw_ctl, output logic saw_cmd,
                             output int cs_cnt, output int pmp_cnt);
        lat = -1; saw_ctl = 0; saw_cmd = 0; cs_cnt = 0; pmp_cnt = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (!eep_cs_n) begin
                cs_cnt++;
                chk("sel_addr", eep_addr, exp_addr);
                chk("sel_rwn", eep_r_w_n, !exp_wr);
            end
            if (chrg_pmp_en) begin
                pmp_cnt++;
                chk("wr_wdata", eep_wdata, exp_wdata);
            end
            if (ctl_done || cmd_done) begin
                saw_ctl = ctl_done;
                saw_cmd = cmd_done;
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    // Transaction-level reference state for the random run
    int            m_start, m_done;
    logic          m_own, m_wr, m_last;
    logic [1:0]    m_eaddr;
    logic [DW-1:0] m_wdata, m_rd;

    int            lat, cs_cnt, pmp_cnt, cmd_at, ctl_at;
    logic          s_ctl, s_cmd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 2'b01, 0, 0, 2'b00, 14'h0000, 14'h01A5, 0, 2,     1, 0, 14'h01A5};
        vecs[1] = '{0, 2'b00, 1, 1, 2'b10, 14'h02C3, 14'h0777, 1, W + 1, W, W, 14'h01A5};
        vecs[2] = '{0, 2'b00, 1, 0, 2'b11, 14'h1111, 14'h3FFF, 1, 2,     1, 0, 14'h3FFF};
        vecs[3] = '{1, 2'b00, 0, 0, 2'b00, 14'h0000, 14'h0042, 0, 2,     1, 0, 14'h0042};

        rst_n = 0;
        idle_inputs();
        #1;
        chk("reset_outputs",
            {eep_cs_n, eep_r_w_n, eep_addr, eep_wdata, chrg_pmp_en, ctl_done, cmd_done, rd_data, busy},
            {1'b1, 1'b1, 2'b00, 14'h0, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0});
        tick();
        rst_n = 1;
        tick();

        // Directed vector table
        for (int k = 0; k < 4; k++) begin
            ctl_req = vecs[k].ctl_req; ctl_addr = vecs[k].ctl_addr;
            cmd_req = vecs[k].cmd_req; cmd_wr = vecs[k].cmd_wr;
            cmd_addr = vecs[k].cmd_addr; cmd_wdata = vecs[k].cmd_wdata;
            eep_rdata = vecs[k].rdata;
            wait_done(40, vecs[k].exp_cmd ? vecs[k].cmd_addr : vecs[k].ctl_addr,
                      vecs[k].exp_cmd & vecs[k].cmd_wr, vecs[k].cmd_wdata,
                      lat, s_ctl, s_cmd, cs_cnt, pmp_cnt);
            ctl_req = 0; cmd_req = 0;
            chk($sformatf("v%0d_done_who", k), {s_ctl, s_cmd}, vecs[k].exp_cmd ? 2'b01 : 2'b10);
            chk($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
            chk($sformatf("v%0d_cs_cycles", k), cs_cnt, vecs[k].exp_cs);
            chk($sformatf("v%0d_pmp_cycles", k), pmp_cnt, vecs[k].exp_pmp);
            chk($sformatf("v%0d_rd_data", k), rd_data, vecs[k].exp_rd);
            tick();
            chk($sformatf("v%0d_back_idle", k), {busy, ctl_done, cmd_done, eep_cs_n}, 4'b0001);
        end

        // Simultaneous requests: ctl first, then cmd; again ctl first after a cmd-only access
        do_reset();
        ctl_req = 1; ctl_addr = 2'b00; cmd_req = 1; cmd_wr = 0; cmd_addr = 2'b10;
        eep_rdata = 14'h0AAA;
        wait_done(20, 2'b00, 0, 14'h0, lat, s_ctl, s_cmd, cs_cnt, pmp_cnt);
        ctl_req = 0; eep_rdata = 14'h0BBB;
        chk("tie1_first", {s_ctl, s_cmd}, 2'b10);
        chk("tie1_rd", rd_data, 14'h0AAA);
        wait_done(20, 2'b10, 0, 14'h0, lat, s_ctl, s_cmd, cs_cnt, pmp_cnt);
        cmd_req = 0;
        chk("tie1_second", {s_ctl, s_cmd}, 2'b01);
        chk("tie1_second_lat", lat, 3);
        chk("tie1_second_rd", rd_data, 14'h0BBB);
        tick();
        cmd_req = 1; cmd_addr = 2'b01; eep_rdata = 14'h0CCC;
        wait_done(20, 2'b01, 0, 14'h0, lat, s_ctl, s_cmd, cs_cnt, pmp_cnt);
        cmd_req = 0;
        chk("cmd_only", {s_ctl, s_cmd}, 2'b01);
        tick();
        ctl_req = 1; ctl_addr = 2'b11; cmd_req = 1; cmd_addr = 2'b00; eep_rdata = 14'h0DDD;
        wait_done(20, 2'b11, 0, 14'h0, lat, s_ctl, s_cmd, cs_cnt, pmp_cnt);
        ctl_req = 0; cmd_req = 0;
        chk("tie2_first", {s_ctl, s_cmd}, 2'b10);

        // ctl request arriving in the third write cycle waits for the full write
        do_reset();
        cmd_req = 1; cmd_wr = 1; cmd_addr = 2'b10; cmd_wdata = 14'h02C3;
        pmp_cnt = 0; cmd_at = -1; ctl_at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (chrg_pmp_en) pmp_cnt++;
            if (cmd_done) begin cmd_at = i; cmd_req = 0; end
            if (ctl_done) begin ctl_at = i; ctl_req = 0; break; end
            if (i == 3) begin ctl_req = 1; ctl_addr = 2'b01; eep_rdata = 14'h0155; end
        end
        chk("wr_pre_pmp_cycles", pmp_cnt, W);
        chk("wr_pre_cmd_done_at", cmd_at, W + 1);
        chk("wr_pre_ctl_done_at", ctl_at, W + 4);
        chk("wr_pre_rd", rd_data, 14'h0155);

        // Reset in the fourth write cycle
        do_reset();
        cmd_req = 1; cmd_wr = 1; cmd_addr = 2'b11; cmd_wdata = 14'h1234;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_mid_pre", {eep_cs_n, chrg_pmp_en}, 2'b01);
        rst_n = 0; cmd_req = 0;
        #1;
        chk("rst_mid_now", {eep_cs_n, chrg_pmp_en, busy, ctl_done, cmd_done}, 5'b10000);
        tick();
        rst_n = 1;
        tick();
        chk("rst_mid_after", {eep_cs_n, chrg_pmp_en, busy, ctl_done, cmd_done}, 5'b10000);
        ctl_req = 1; ctl_addr = 2'b10; eep_rdata = 14'h2468;
        wait_done(20, 2'b10, 0, 14'h0, lat, s_ctl, s_cmd, cs_cnt, pmp_cnt);
        ctl_req = 0;
        chk("rst_mid_read_who", {s_ctl, s_cmd}, 2'b10);
        chk("rst_mid_read_lat", lat, 2);
        chk("rst_mid_read_rd", rd_data, 14'h2468);

        // Randomized run against a transaction-level model
        do_reset();
        m_start = -10; m_done = -10; m_own = 0; m_wr = 0; m_last = 1;
        m_eaddr = 0; m_wdata = 0; m_rd = 0;
        for (int c = 0; c < 3000; c++) begin
            logic act_sel, act_wr, in_txn;
            act_sel = (c >= m_start) && (c < m_done);
            act_wr  = act_sel && m_wr;
            in_txn  = (c >= m_start) && (c <= m_done);
            chk("rnd_outputs",
                {eep_cs_n, eep_r_w_n, chrg_pmp_en, busy, ctl_done, cmd_done, eep_addr, rd_data},
                {!act_sel, !act_wr, act_wr, in_txn, (c == m_done) && !m_own,
                 (c == m_done) && m_own, m_eaddr, m_rd});
            if (act_wr) chk("rnd_wdata", eep_wdata, m_wdata);

            if (c == m_done && !m_own) begin
                if ($urandom_range(1, 0) == 1) ctl_addr = 2'($urandom);
                else ctl_req = 0;
            end else if (!ctl_req && $urandom_range(3, 0) == 0) begin
                ctl_req = 1; ctl_addr = 2'($urandom);
            end
            if (c == m_done && m_own) begin
                if ($urandom_range(1, 0) == 1) begin
                    cmd_wr = ($urandom_range(2, 0) == 0); cmd_addr = 2'($urandom);
                    cmd_wdata = 14'($urandom);
                end else cmd_req = 0;
            end else if (!cmd_req && $urandom_range(3, 0) == 0) begin
                cmd_req = 1; cmd_wr = ($urandom_range(2, 0) == 0);
                cmd_addr = 2'($urandom); cmd_wdata = 14'($urandom);
            end
            eep_rdata = 14'($urandom);

            if (c == m_start && !m_wr) m_rd = eep_rdata;
            if (c > m_done && (ctl_req || cmd_req)) begin
                m_own   = (ctl_req && cmd_req) ? !m_last : cmd_req;
                m_last  = m_own;
                m_wr    = m_own && cmd_wr;
                m_start = c + 1;
                m_done  = m_wr ? c + W + 1 : c + 2;
                m_eaddr = m_own ? cmd_addr : ctl_addr;
                if (m_own) m_wdata = cmd_wdata;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
